spike_array_core: RTL and testbench

//  Pipelined N-lane spike-based dot product: result = sum_i w[i]*a[i].

---
 rtl/spike_array_core_if.sv | 15 +
 rtl/spike_array_core.sv | 95 +++++++++
 tb/tb_spike_array_core.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spike_array_core_if.sv
// Batch bus of the spike dot-product leaf: one batch of weights and activations in,
// one result with its done pulse out.
interface spike_array_core_if #(
    parameter int N        = 128,
    parameter int BITWIDTH = 4
);
    logic                    start;
    logic [N*4-1:0]          i_weights_flat;
    logic [N*BITWIDTH-1:0]   i_acts_flat;
    logic                    done;
    logic signed [15:0]      result;

    modport master (output start, i_weights_flat, i_acts_flat, input done, result);
    modport slave  (input start, i_weights_flat, i_acts_flat, output done, result);
endinterface

// File: rtl/spike_array_core.sv
// Pipelined N-lane dot product: activations are split into bit-plane spikes that gate
// the weights into one registered adder tree per plane; planes are recombined at the end.
module spike_lane #(
    parameter int BITWIDTH = 4,
    parameter int PW       = 12
) (
    input  logic                              clk,
    input  logic [3:0]                        i_w,
    input  logic [BITWIDTH-1:0]               i_a,
    output logic [BITWIDTH-1:0][PW-1:0]       o_gate
);
    logic [3:0]                        r_w;
    logic [BITWIDTH-1:0]               r_a;
    logic [BITWIDTH-1:0][PW-1:0]       r_gate;
    logic [PW-1:0]                     w_sext;

    assign w_sext = {{(PW-4){r_w[3]}}, r_w};

    // Capture stage, then the gated plane operands one stage later.
    always_ff @(posedge clk) begin
        r_w <= i_w;
        r_a <= i_a;
        for (int k = 0; k < BITWIDTH; k++)
            r_gate[k] <= r_a[k] ? w_sext : '0;
    end

    assign o_gate = r_gate;
endmodule

module spike_array_core #(
    parameter int N        = 128,
    parameter int BITWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    spike_array_core_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int LAT  = LOGN + 2;
    localparam int PW   = 5 + LOGN;
    localparam int FW0  = PW + BITWIDTH;
    localparam int FW   = (FW0 > 16) ? FW0 : 16;

    logic [LAT:0]                              r_vld_pipe;
    logic [N-1:0][BITWIDTH-1:0][PW-1:0]        w_lane_gate;
    logic signed [PW-1:0]                      r_node [BITWIDTH][1:N-1];
    logic signed [PW-1:0]                      w_all  [BITWIDTH][2:2*N-1];
    logic signed [FW-1:0]                      w_sum;
    logic signed [15:0]                        r_result;

    for (genvar i = 0; i < N; i++) begin : g_lane
        spike_lane #(.BITWIDTH(BITWIDTH), .PW(PW)) u_lane (
            .clk    (clk),
            .i_w    (bus.i_weights_flat[i*4 +: 4]),
            .i_a    (bus.i_acts_flat[i*BITWIDTH +: BITWIDTH]),
            .o_gate (w_lane_gate[i])
        );
    end

    // Heap-indexed tree: node j sums children 2j and 2j+1; indices >= N are lane leaves.
    always_comb begin
        for (int k = 0; k < BITWIDTH; k++) begin
            for (int j = 2; j < N; j++)
                w_all[k][j] = r_node[k][j];
            for (int j = N; j < 2*N; j++)
                w_all[k][j] = w_lane_gate[j-N][k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < BITWIDTH; k++)
            for (int j = 1; j < N; j++)
                r_node[k][j] <= w_all[k][2*j] + w_all[k][2*j+1];
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < BITWIDTH; k++)
            w_sum = w_sum + (FW'(r_node[k][1]) << k);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_result   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LAT-1:0], bus.start};
            if (r_vld_pipe[LAT-1])
                r_result <= w_sum[15:0];
        end
    end

    assign bus.done   = r_vld_pipe[LAT];
    assign bus.result = r_result;
endmodule

// File: tb/tb_spike_array_core.sv
// Bench for spike_array_core: constant vectors, random streams, bubbles and mid-stream reset,
// all scored cycle-exactly against a plain-arithmetic dot-product model.
module tb_spike_array_core;
    localparam int N   = 128;
    localparam int BW  = 4;
    localparam int LAT = 9;

    typedef struct {
        string              name;
        logic [N*4-1:0]     w;
        logic [N*BW-1:0]    a;
        logic signed [15:0] exp;
    } vec_t;

    typedef struct {
        int                 slot;
        logic signed [15:0] val;
    } pend_t;

    logic clk = 0;
    logic rst = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    bit   chk_en = 0;
    logic signed [15:0] last_res = 0;
    pend_t q[$];
    vec_t  tbl[6];

    spike_array_core_if #(.N(N), .BITWIDTH(BW)) bus ();
    spike_array_core #(.N(N), .BITWIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic signed [15:0] golden(input logic [N*4-1:0] w, input logic [N*BW-1:0] a);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int wi, ai;
            wi = $signed(w[i*4 +: 4]);
            ai = a[i*BW +: BW];
            s += wi * ai;
        end
        return 16'(s);
    endfunction

    // Each call owns exactly one clock: inputs set just after an edge, sampled at the next.
    task automatic drive(input logic [N*4-1:0] w, input logic [N*BW-1:0] a, input logic s,
                         input logic signed [15:0] exp);
        pend_t p;
        @(posedge clk); #1;
        bus.start          = s;
        bus.i_weights_flat = w;
        bus.i_acts_flat    = a;
        if (s) begin
            p.slot = cyc + 1 + LAT;
            p.val  = exp;
            q.push_back(p);
        end
    endtask

    task automatic rnd(output logic [N*4-1:0] w, output logic [N*BW-1:0] a);
        for (int j = 0; j < N*4/32; j++) w[j*32 +: 32] = $urandom();
        for (int j = 0; j < N*BW/32; j++) a[j*32 +: 32] = $urandom();
    endtask

    task automatic idle(input int n);
        logic [N*4-1:0]  w;
        logic [N*BW-1:0] a;
        for (int i = 0; i < n; i++) begin
            rnd(w, a);
            drive(w, a, 1'b0, 16'sd0);
        end
    endtask

    // Cycle-exact scoreboard: done must appear exactly in the slot of the queue head.
    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].slot == cyc) begin
                chk("done", int'(bus.done), 1);
                chk("result", int'(bus.result), int'(q[0].val));
                last_res = q[0].val;
                void'(q.pop_front());
            end else begin
                chk("done_idle", int'(bus.done), 0);
                chk("result_hold", int'(bus.result), int'(last_res));
            end
            if (bus.done) ndone++;
        end
    end

    initial begin
        logic [N*4-1:0]  w;
        logic [N*BW-1:0] a;
        int              n0;

        for (int i = 0; i < N; i++) begin
            tbl[0].w[i*4 +: 4] = 4'h1; tbl[0].a[i*BW +: BW] = 4'd1;
            tbl[1].w[i*4 +: 4] = 4'h8; tbl[1].a[i*BW +: BW] = 4'd15;
            tbl[2].w[i*4 +: 4] = 4'h7; tbl[2].a[i*BW +: BW] = 4'd15;
            tbl[3].w[i*4 +: 4] = (i % 2 == 0) ? 4'h3 : 4'hD; tbl[3].a[i*BW +: BW] = 4'd5;
            tbl[4].w[i*4 +: 4] = (i == 5) ? 4'hF : 4'h7; tbl[4].a[i*BW +: BW] = (i == 5) ? 4'd1 : 4'd0;
            tbl[5].w[i*4 +: 4] = 4'h2; tbl[5].a[i*BW +: BW] = BW'(i % 16);
        end
        tbl[0].name = "ones";     tbl[0].exp = 16'sd128;
        tbl[1].name = "min";      tbl[1].exp = -16'sd15360;
        tbl[2].name = "max";      tbl[2].exp = 16'sd13440;
        tbl[3].name = "alt";      tbl[3].exp = 16'sd0;
        tbl[4].name = "one_lane"; tbl[4].exp = -16'sd1;
        tbl[5].name = "ramp";     tbl[5].exp = 16'sd1920;

        bus.start = 0; bus.i_weights_flat = '0; bus.i_acts_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        rst = 1;
        chk_en = 1;

        foreach (tbl[t]) begin
            drive(tbl[t].w, tbl[t].a, 1'b1, tbl[t].exp);
            idle(LAT + 2);
        end

        n0 = ndone;
        for (int i = 0; i < 1024; i++) begin
            rnd(w, a);
            drive(w, a, 1'b1, golden(w, a));
        end
        idle(LAT + 3);
        chk("stream_count", ndone - n0, 1024);
        chk("stream_drain", q.size(), 0);

        rnd(w, a); drive(w, a, 1'b1, golden(w, a));
        rnd(w, a); drive(w, a, 1'b0, 16'sd0);
        rnd(w, a); drive(w, a, 1'b1, golden(w, a));
        idle(LAT + 2);
        chk("bubble_drain", q.size(), 0);

        n0 = ndone;
        for (int i = 0; i < 200; i++) begin
            logic s;
            rnd(w, a);
            s = 1'($urandom_range(0, 1));
            drive(w, a, s, golden(w, a));
        end
        idle(LAT + 2);
        chk("rand_start_drain", q.size(), 0);

        for (int i = 0; i < 5; i++) begin
            rnd(w, a);
            drive(w, a, 1'b1, golden(w, a));
        end
        @(posedge clk); #3;
        rst = 0; bus.start = 0;
        q.delete(); last_res = 0;
        #1;
        chk("rst_mid_done", int'(bus.done), 0);
        chk("rst_mid_result", int'(bus.result), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        n0 = ndone;
        rnd(w, a);
        drive(w, a, 1'b1, golden(w, a));
        idle(LAT + 3);
        chk("post_rst_count", ndone - n0, 1);
        chk("post_rst_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
